hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Generates stall, flush and forwarding selects from stage register addresses and control bits.
- Freezes the whole pipeline while a data-memory access is outstanding, with a bounded wait and a sticky timeout error.
- Counts stall cycles and branch flushes for performance debug. Instantiated in the core top alongside the fetch/decode/execute/memory stages.

---
 rtl/hazard_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stall/flush/forwarding
// generation, bounded data-memory wait with sticky timeout, and performance counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       EX_rs1,
    input  logic [4:0]       EX_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_regwrite,
    input  logic             EX_wb_sel,
    input  logic [4:0]       MEM_rd,
    input  logic             MEM_regwrite,
    input  logic [4:0]       WB_rd,
    input  logic             WB_regwrite,
    input  logic             PC_sel,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             flush_WB,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int unsigned        WAIT_W    = 16;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_busy;
    logic wait_expired;
    logic branch_flush;

    // MEM is the younger producer, so its result wins over WB.
    function automatic logic [1:0] fwd_src(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_MEM;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return FWD_WB;
        return FWD_RF;
    endfunction

    assign fwdA_sel = fwd_src(EX_rs1, MEM_rd, MEM_regwrite, WB_rd, WB_regwrite);
    assign fwdB_sel = fwd_src(EX_rs2, MEM_rd, MEM_regwrite, WB_rd, WB_regwrite);

    assign load_use = EX_wb_sel && EX_regwrite && (EX_rd != 5'd0) &&
                      ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
    assign mem_busy     = dmem_req && !dmem_ready;
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_expired) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_IF     = 1'b0;
        stall_ID     = 1'b0;
        stall_EX     = 1'b0;
        stall_MEM    = 1'b0;
        flush_ID     = 1'b0;
        flush_EX     = 1'b0;
        flush_WB     = 1'b0;
        branch_flush = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    stall_IF  = 1'b1;
                    stall_ID  = 1'b1;
                    stall_EX  = 1'b1;
                    stall_MEM = 1'b1;
                    flush_WB  = 1'b1;
                end else if (PC_sel) begin
                    flush_ID     = 1'b1;
                    flush_EX     = 1'b1;
                    branch_flush = 1'b1;
                end else if (load_use) begin
                    stall_IF = 1'b1;
                    stall_ID = 1'b1;
                    flush_EX = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    // The released EX instruction resolves its branch/hazard now.
                    if (PC_sel) begin
                        flush_ID     = 1'b1;
                        flush_EX     = 1'b1;
                        branch_flush = 1'b1;
                    end else if (load_use) begin
                        stall_IF = 1'b1;
                        stall_ID = 1'b1;
                        flush_EX = 1'b1;
                    end
                end else if (wait_expired) begin
                    flush_WB = 1'b1;
                end else begin
                    stall_IF  = 1'b1;
                    stall_ID  = 1'b1;
                    stall_EX  = 1'b1;
                    stall_MEM = 1'b1;
                    flush_WB  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_IF && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
